alu_op_sequencer: RTL

//   Command-side driver for the 8-bit ALU datapath (Interconnections).
//   - Accepts operation commands over a valid/ready handshake.
//   - Registers and drives the datapath inputs Inbus, Aside, Bside, select_source and Function.
//   - Samples Outbus and returns it over a valid/ready response channel.
//   - Keeps the last result in an accumulator so a command can chain it back onto Inbus.

---
 rtl/alu_seq_pkg.sv | 19 +
 rtl/alu_op_sequencer.sv | 112 +++++++++++
 2 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU command sequencer: FSM encoding, ALU function codes, default width.
package alu_seq_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    FN_ADD = 2'b00,
    FN_SUB = 2'b01,
    FN_AND = 2'b10,
    FN_OR  = 2'b11
  } alu_fn_e;

endpackage

// File: rtl/alu_op_sequencer.sv
// Command-side driver for the 8-bit ALU datapath: registers operands, samples Outbus one cycle later.
// Latency: accept -> one DRIVE cycle -> rsp_valid; cmd_ready only in IDLE, response held until rsp_ready.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_func,
  input  logic              cmd_sel,
  input  logic              cmd_chain,
  input  logic [DATA_W-1:0] cmd_in,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic [DATA_W-1:0] Inbus,
  output logic [DATA_W-1:0] Aside,
  output logic [DATA_W-1:0] Bside,
  output logic              select_source,
  output logic [1:0]        Function,
  input  logic [DATA_W-1:0] Outbus,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [CNT_W-1:0]  op_count
);

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  inbus_q, inbus_d;
  logic [DATA_W-1:0]  aside_q, aside_d;
  logic [DATA_W-1:0]  bside_q, bside_d;
  logic               sel_q, sel_d;
  logic [1:0]         func_q, func_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic [DATA_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]   op_count_q, op_count_d;

  always_comb begin
    state_d    = state_q;
    inbus_d    = inbus_q;
    aside_d    = aside_q;
    bside_d    = bside_q;
    sel_d      = sel_q;
    func_d     = func_q;
    rsp_data_d = rsp_data_q;
    acc_d      = acc_q;
    op_count_d = op_count_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          inbus_d = cmd_chain ? acc_q : cmd_in;
          aside_d = cmd_a;
          bside_d = cmd_b;
          sel_d   = cmd_sel;
          func_d  = cmd_func;
          state_d = DRIVE;
        end
      end
      // Outbus is combinational from the operand registers, so it is settled by the end of DRIVE.
      DRIVE: begin
        rsp_data_d = Outbus;
        acc_d      = Outbus;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          op_count_d = op_count_q + CNT_W'(1);
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      inbus_q    <= '0;
      aside_q    <= '0;
      bside_q    <= '0;
      sel_q      <= 1'b0;
      func_q     <= 2'b00;
      rsp_data_q <= '0;
      acc_q      <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      inbus_q    <= inbus_d;
      aside_q    <= aside_d;
      bside_q    <= bside_d;
      sel_q      <= sel_d;
      func_q     <= func_d;
      rsp_data_q <= rsp_data_d;
      acc_q      <= acc_d;
      op_count_q <= op_count_d;
    end
  end

  assign cmd_ready     = (state_q == IDLE);
  assign rsp_valid     = (state_q == RESP);
  assign Inbus         = inbus_q;
  assign Aside         = aside_q;
  assign Bside         = bside_q;
  assign select_source = sel_q;
  assign Function      = func_q;
  assign rsp_data      = rsp_data_q;
  assign op_count      = op_count_q;

endmodule
